bcd_para_binario: RTL
=====================

BCD_PARA_BINARIO -- requirements
Module: bcd_para_binario

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports as follows:
- clk  input  1  rising-edge clock, the only clock.
- rst_n  input  1  asynchronous, active-low reset.
- iniciar  input  1  start request, one-cycle pulse or level, sampled at the clk rising edge.
- bcd_centenas  input  4  hundreds BCD digit.
- bcd_dezenas  input  4  tens BCD digit.
- bcd_unidades  input  4  units BCD digit.
- binario  output  8  converted value, registered.
- erro  output  1  error flag for the last conversion, registered.
- ocupado  output  1  high while a conversion is in progress.
- concluido  output  1  one-cycle pulse when binario and erro are updated.

REQ-002 The block SHALL have no parameters; all widths are fixed as listed.

Function
REQ-003 The block SHALL compute V = 100*C + 10*D + U, where C, D and U are the hundreds, tens and units digits.
- Computation is iterative: one bit per cycle, by reverse double-dabble (shift right, then subtract 3 from any BCD nibble >= 8).
- Internal result width is 10 bits.

REQ-004 The FSM SHALL have three states: OCIOSO, CONVERTE and CONCLUI.
- Reset state is OCIOSO.

REQ-005 In OCIOSO, iniciar=1 at a rising edge SHALL trigger the following at that edge (E0):
- All three digits are captured into an internal 12-bit register.
- The iteration counter is cleared.
- The FSM moves to CONVERTE, and ocupado=1 from E0.

REQ-006 Input digits SHALL only be sampled at E0.
- Changes on the bcd_* inputs after E0 do not affect the conversion in progress.

REQ-007 CONVERTE SHALL perform exactly 10 shift/adjust steps, at edges E1..E10.
- Latency is fixed at 10 steps regardless of input values, including erroneous inputs.

REQ-008 At E10 the FSM SHALL move to CONCLUI and update binario and erro.
- concluido=1 and ocupado=0 for the single cycle after E10.
- At E11 the FSM returns to OCIOSO and concluido=0.

REQ-009 iniciar=1 while the FSM is in CONVERTE SHALL be ignored, with no restart and no queuing.

REQ-010 iniciar=1 while the FSM is in CONCLUI SHALL be accepted as a new E0.
- The next conversion starts at E11, giving back-to-back throughput of one result per 11 cycles.

REQ-011 Any digit > 9 (values A-F) SHALL set erro=1 and binario=8'h00 at completion.
- The invalid-digit check is evaluated on the values captured at E0.

REQ-012 All-valid digits with V > 255 SHALL set erro=1 and binario=8'h00 at completion.
- Example: 256..999.

REQ-013 All-valid digits with V <= 255 SHALL set erro=0 and binario=V[7:0] at completion.

REQ-014 binario and erro SHALL hold their last values until the next completion.
- Starting a new conversion does not clear them.

REQ-015 All outputs SHALL be driven from registers, with no combinational path from any input to any output.

Reset
REQ-016 While rst_n=0, asynchronously and regardless of state, the block SHALL set:
- the FSM to OCIOSO;
- binario=8'h00, erro=0, ocupado=0, concluido=0;
- all internal registers and the counter to 0.

REQ-017 Reset asserted mid-conversion SHALL abort the conversion.
- No concluido pulse is produced, and binario and erro read 0.

REQ-018 After rst_n deasserts, the first rising edge SHALL be able to accept iniciar.

Verification
REQ-019 The bench SHALL cover the following directed scenarios:
- 2,5,5 with an iniciar pulse -> ocupado=1 for 10 cycles; concluido=1 on the 11th cycle after E0 with binario=8'hFF, erro=0.
- 0,0,0 -> binario=8'h00, erro=0, same latency.
- 2,5,6, then 9,9,9 -> erro=1, binario=8'h00 for both.
- 1,A,3 -> erro=1, binario=8'h00; the latency is still 10 steps.
- iniciar held high continuously with 1,2,8 -> concluido pulses every 11 cycles with binario=8'h80; inputs changed mid-conversion do not alter the result.
- rst_n pulsed low at step 5 of 1,0,0 -> outputs 0, no concluido; a following conversion of 0,4,2 gives 8'h2A.

REQ-020 The bench SHALL run an exhaustive sweep of all valid C,D,U (0..999) and check every result against 100*C+10*D+U, including the error rule for V > 255.

Source files
------------

// File: rtl/bcd_para_binario.sv
// rtl/bcd_para_binario.sv - three-digit BCD to 8-bit binary converter
// Reverse double-dabble, one bit per cycle; out-of-range or invalid digits flag erro.
module bcd_para_binario (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       iniciar,
    input  logic [3:0] bcd_centenas,
    input  logic [3:0] bcd_dezenas,
    input  logic [3:0] bcd_unidades,
    output logic [7:0] binario,
    output logic       erro,
    output logic       ocupado,
    output logic       concluido
);
    typedef enum logic [1:0] {OCIOSO, CONVERTE, CONCLUI} estado_t;

    estado_t     estado;
    estado_t     proximo;
    logic [21:0] reg_conv;      // {C, D, U, 10-bit binary accumulator}
    logic [21:0] passo;
    logic [3:0]  contador;
    logic        invalido;
    logic        inicio;

    assign inicio = iniciar && (estado != CONVERTE);

    // One step: shift the whole BCD:binary word right, then correct each digit >= 8.
    always_comb begin
        passo = {1'b0, reg_conv[21:1]};
        for (int i = 0; i < 3; i++) begin
            if (passo[10 + 4*i +: 4] >= 4'd8)
                passo[10 + 4*i +: 4] = passo[10 + 4*i +: 4] - 4'd3;
        end
    end

    always_comb begin
        proximo = estado;
        case (estado)
            OCIOSO:   if (iniciar) proximo = CONVERTE;
            CONVERTE: if (contador == 4'd9) proximo = CONCLUI;
            CONCLUI:  proximo = iniciar ? CONVERTE : OCIOSO;
            default:  proximo = OCIOSO;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            estado <= OCIOSO;
        else
            estado <= proximo;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_conv  <= 22'd0;
            contador  <= 4'd0;
            invalido  <= 1'b0;
            binario   <= 8'h00;
            erro      <= 1'b0;
            ocupado   <= 1'b0;
            concluido <= 1'b0;
        end else begin
            concluido <= 1'b0;
            if (inicio) begin
                reg_conv <= {bcd_centenas, bcd_dezenas, bcd_unidades, 10'd0};
                contador <= 4'd0;
                invalido <= (bcd_centenas > 4'd9) || (bcd_dezenas > 4'd9) ||
                            (bcd_unidades > 4'd9);
                ocupado  <= 1'b1;
            end else if (estado == CONVERTE) begin
                reg_conv <= passo;
                contador <= contador + 4'd1;
                if (contador == 4'd9) begin
                    ocupado   <= 1'b0;
                    concluido <= 1'b1;
                    // Valid digits give V <= 999, so any bit above 7 means V > 255.
                    if (invalido || (passo[9:8] != 2'b00)) begin
                        binario <= 8'h00;
                        erro    <= 1'b1;
                    end else begin
                        binario <= passo[7:0];
                        erro    <= 1'b0;
                    end
                end
            end
        end
    end
endmodule
